// File: rtl/quiz_round_if.sv
// Bus between the quiz round controller and the host/player/timer side.
// The master side drives host keys, player keys and the timer expiry; the
// slave side (the controller) drives the pulses, grant, lockout and scores.
interface quiz_round_if #(
    parameter int SCORE_W = 6
);
    logic                   arm;
    logic [3:0]             key_in;
    logic                   judge_ok;
    logic                   judge_bad;
    logic                   timer_expired;
    logic                   start_pulse;
    logic                   answer_pulse;
    logic [3:0]             grant;
    logic [3:0]             lockout;
    logic [4*SCORE_W-1:0]   scores;
    logic [7:0]             round_num;
    logic                   game_over;

    modport master (
        output arm, key_in, judge_ok, judge_bad, timer_expired,
        input  start_pulse, answer_pulse, grant, lockout, scores, round_num, game_over
    );

    modport slave (
        input  arm, key_in, judge_ok, judge_bad, timer_expired,
        output start_pulse, answer_pulse, grant, lockout, scores, round_num, game_over
    );
endinterface

// File: rtl/quiz_round_ctrl.sv
// Quiz round sequencer and fair round-robin arbiter for four players.
// Runs arm -> countdown -> open window -> grant -> judge -> score, keeps
// saturating per-player scores and counts completed rounds up to game over.
// After a wrong answer/timeout the window reopens one cycle after the
// answer pulse so that start and answer pulses are never high together.
module quiz_round_ctrl #(
    parameter logic [15:0] ARM_DELAY = 16'd50000,
    parameter int          N_ROUNDS  = 8,
    parameter int          SCORE_W   = 6,
    parameter int          PTS_OK    = 2,
    parameter int          PTS_BAD   = 1
) (
    input  logic          clk,
    input  logic          rst,
    quiz_round_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PRE   = 3'd1,
        OPEN  = 3'd2,
        GRANT = 3'd3,
        RDONE = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam logic [SCORE_W:0] OK_W  = (SCORE_W+1)'(PTS_OK);
    localparam logic [SCORE_W:0] BAD_W = (SCORE_W+1)'(PTS_BAD);
    localparam logic [SCORE_W:0] SMAX  = {1'b0, {SCORE_W{1'b1}}};
    localparam logic [7:0]       N_R   = 8'(N_ROUNDS);

    // Saturating add: clamps at the all-ones score instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                    input logic [SCORE_W:0]   p);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + p;
        if (sum > SMAX) begin
            return SMAX[SCORE_W-1:0];
        end else begin
            return sum[SCORE_W-1:0];
        end
    endfunction

    // Saturating subtract: clamps at zero instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_sub(input logic [SCORE_W-1:0] s,
                                                    input logic [SCORE_W:0]   p);
        logic [SCORE_W:0] diff;
        diff = {1'b0, s} - p;
        if ({1'b0, s} < p) begin
            return {SCORE_W{1'b0}};
        end else begin
            return diff[SCORE_W-1:0];
        end
    endfunction

    // Round-robin pick: first requester found scanning upward from ptr.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] res;
        logic       found;
        res   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    state_t              state_r, state_n;
    logic [15:0]         cnt_r, cnt_n;
    logic [3:0]          key_prev_r;
    logic [1:0]          rr_r, rr_n;
    logic [1:0]          win_r, win_n;
    logic                reopen_r, reopen_n;
    logic                start_r, start_n;
    logic                answer_r, answer_n;
    logic [3:0]          grant_r, grant_n;
    logic [3:0]          lockout_r, lockout_n;
    logic [SCORE_W-1:0]  score_r [4];
    logic [SCORE_W-1:0]  score_n [4];
    logic [7:0]          round_r, round_n;
    logic                over_r, over_n;

    logic [3:0]          key_edge_s;
    logic [3:0]          elig_s;
    logic [1:0]          pick_s;

    assign key_edge_s = bus.key_in & ~key_prev_r;
    assign elig_s     = key_edge_s & ~lockout_r;
    assign pick_s     = rr_pick(elig_s, rr_r);

    // Next-state and next-output decode for the round sequencer.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        rr_n      = rr_r;
        win_n     = win_r;
        reopen_n  = 1'b0;
        start_n   = 1'b0;
        answer_n  = 1'b0;
        grant_n   = grant_r;
        lockout_n = lockout_r;
        score_n   = score_r;
        round_n   = round_r;
        over_n    = over_r;

        case (state_r)
            IDLE: begin
                if (bus.arm) begin
                    lockout_n = 4'b0000;
                    cnt_n     = ARM_DELAY - 16'd1;
                    state_n   = PRE;
                end else begin
                    state_n = IDLE;
                end
            end

            PRE: begin
                // Early presses are false starts: lock out and penalise once.
                for (int i = 0; i < 4; i++) begin
                    if (key_edge_s[i] && !lockout_r[i]) begin
                        lockout_n[i] = 1'b1;
                        score_n[i]   = sat_sub(score_r[i], BAD_W);
                    end else begin
                        lockout_n[i] = lockout_n[i];
                    end
                end
                if (cnt_r == 16'd0) begin
                    if (lockout_n == 4'b1111) begin
                        state_n = RDONE;
                    end else begin
                        state_n = OPEN;
                        start_n = 1'b1;
                    end
                end else begin
                    cnt_n = cnt_r - 16'd1;
                end
            end

            OPEN: begin
                start_n = reopen_r;
                if (elig_s != 4'b0000) begin
                    grant_n = 4'b0001 << pick_s;
                    rr_n    = pick_s + 2'd1;
                    win_n   = pick_s;
                    state_n = GRANT;
                end else begin
                    state_n = OPEN;
                end
            end

            GRANT: begin
                if (bus.judge_ok) begin
                    score_n[win_r] = sat_add(score_r[win_r], OK_W);
                    answer_n       = 1'b1;
                    grant_n        = 4'b0000;
                    state_n        = RDONE;
                end else if (bus.judge_bad || bus.timer_expired) begin
                    score_n[win_r]   = sat_sub(score_r[win_r], BAD_W);
                    lockout_n[win_r] = 1'b1;
                    answer_n         = 1'b1;
                    grant_n          = 4'b0000;
                    if (lockout_n != 4'b1111) begin
                        state_n  = OPEN;
                        reopen_n = 1'b1;
                    end else begin
                        state_n = RDONE;
                    end
                end else begin
                    state_n = GRANT;
                end
            end

            RDONE: begin
                round_n = round_r + 8'd1;
                if (round_r + 8'd1 == N_R) begin
                    state_n = OVER;
                    over_n  = 1'b1;
                end else begin
                    state_n = IDLE;
                end
            end

            OVER: begin
                state_n = OVER;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 16'd0;
            key_prev_r <= 4'b0000;
            rr_r       <= 2'd0;
            win_r      <= 2'd0;
            reopen_r   <= 1'b0;
            start_r    <= 1'b0;
            answer_r   <= 1'b0;
            grant_r    <= 4'b0000;
            lockout_r  <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                score_r[i] <= {SCORE_W{1'b0}};
            end
            round_r    <= 8'd0;
            over_r     <= 1'b0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            key_prev_r <= bus.key_in;
            rr_r       <= rr_n;
            win_r      <= win_n;
            reopen_r   <= reopen_n;
            start_r    <= start_n;
            answer_r   <= answer_n;
            grant_r    <= grant_n;
            lockout_r  <= lockout_n;
            score_r    <= score_n;
            round_r    <= round_n;
            over_r     <= over_n;
        end
    end

    assign bus.start_pulse  = start_r;
    assign bus.answer_pulse = answer_r;
    assign bus.grant        = grant_r;
    assign bus.lockout      = lockout_r;
    assign bus.scores       = {score_r[3], score_r[2], score_r[1], score_r[0]};
    assign bus.round_num    = round_r;
    assign bus.game_over    = over_r;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Scoreboard bench for quiz_round_ctrl: directed rounds push expected
// snapshots; a monitor pops and compares whenever the DUT shows an event
// (start pulse, answer pulse, new grant, round counter change).
module tb_quiz_round_ctrl;

    localparam logic [3:0] K_START = 4'b1000;
    localparam logic [3:0] K_ANS   = 4'b0100;
    localparam logic [3:0] K_GRANT = 4'b0010;
    localparam logic [3:0] K_ROUND = 4'b0001;
    localparam logic [3:0] K_NONE  = 4'b0000;

    typedef logic [44:0] snap_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    snap_t exp_q[$];
    string name_q[$];

    always #5 clk = ~clk;

    quiz_round_if #(.SCORE_W(6)) bus ();

    quiz_round_ctrl #(
        .ARM_DELAY (16'd8),
        .N_ROUNDS  (2),
        .SCORE_W   (6),
        .PTS_OK    (2),
        .PTS_BAD   (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic snap_t mk(input logic [3:0] k, input logic [3:0] g, input logic [3:0] l,
                                 input logic [5:0] s3, input logic [5:0] s2,
                                 input logic [5:0] s1, input logic [5:0] s0,
                                 input logic [7:0] rn, input logic go);
        return {k, g, l, s3, s2, s1, s0, rn, go};
    endfunction

    function automatic snap_t now_snap();
        return {K_NONE, bus.grant, bus.lockout, bus.scores, bus.round_num, bus.game_over};
    endfunction

    task automatic chk(input string nm, input snap_t act, input snap_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input snap_t e);
        name_q.push_back(nm);
        exp_q.push_back(e);
    endtask

    // Monitor: pop and compare one expectation per DUT event.
    logic [3:0] prev_grant;
    logic [7:0] prev_rn;
    always @(negedge clk) begin
        logic [3:0] kind;
        snap_t      act;
        if (rst) begin
            prev_grant = bus.grant;
            prev_rn    = bus.round_num;
        end else begin
            kind = {bus.start_pulse, bus.answer_pulse,
                    (bus.grant != 4'b0000) && (prev_grant == 4'b0000),
                    bus.round_num != prev_rn};
            if (kind != 4'b0000) begin
                act = {kind, bus.grant, bus.lockout, bus.scores, bus.round_num, bus.game_over};
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: got %h expected none", act);
                end else begin
                    chk(name_q.pop_front(), act, exp_q.pop_front());
                end
            end
            prev_grant = bus.grant;
            prev_rn    = bus.round_num;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, exp_q.size());
            exp_q.delete();
            name_q.delete();
        end
    endtask

    // Arm pulse, then optionally hold keys for two cycles during the countdown.
    task automatic arm_p(input logic [3:0] keys);
        @(negedge clk);
        bus.arm = 1'b1;
        @(negedge clk);
        bus.arm = 1'b0;
        bus.key_in = keys;
        cyc(2);
        bus.key_in = 4'b0000;
    endtask

    task automatic press(input logic [3:0] keys);
        @(negedge clk);
        bus.key_in = keys;
        cyc(2);
        bus.key_in = 4'b0000;
    endtask

    task automatic judge(input logic ok, input logic bad, input logic tmo);
        @(negedge clk);
        bus.judge_ok      = ok;
        bus.judge_bad     = bad;
        bus.timer_expired = tmo;
        @(negedge clk);
        bus.judge_ok      = 1'b0;
        bus.judge_bad     = 1'b0;
        bus.timer_expired = 1'b0;
    endtask

    task automatic do_reset(input string nm);
        @(negedge clk);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        chk(nm, now_snap(), mk(K_NONE, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
    endtask

    initial begin
        bus.arm = 1'b0; bus.key_in = 4'b0000;
        bus.judge_ok = 1'b0; bus.judge_bad = 1'b0; bus.timer_expired = 1'b0;
        cyc(3);
        rst = 1'b0;
        cyc(1);
        chk("reset_state", now_snap(), mk(K_NONE, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));

        // A1: P2 wins and answers correctly.
        push("a1_start", mk(K_START, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        arm_p(4'b0000); drain("a1_start");
        push("a1_grant", mk(K_GRANT, 4'b0100, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        press(4'b0100); drain("a1_grant");
        push("a1_answer", mk(K_ANS, 4'h0, 4'h0, 6'd0, 6'd2, 6'd0, 6'd0, 8'd0, 1'b0));
        push("a1_round", mk(K_ROUND, 4'h0, 4'h0, 6'd0, 6'd2, 6'd0, 6'd0, 8'd1, 1'b0));
        judge(1'b1, 1'b0, 1'b0); drain("a1_answer");

        // A2: P1 false start (score saturates at 0), ignored in window; P0 wins.
        push("a2_start", mk(K_START, 4'h0, 4'b0010, 6'd0, 6'd2, 6'd0, 6'd0, 8'd1, 1'b0));
        arm_p(4'b0010); drain("a2_start");
        press(4'b0010); cyc(4);
        push("a2_grant", mk(K_GRANT, 4'b0001, 4'b0010, 6'd0, 6'd2, 6'd0, 6'd0, 8'd1, 1'b0));
        press(4'b0001); drain("a2_grant");
        push("a2_answer", mk(K_ANS, 4'h0, 4'b0010, 6'd0, 6'd2, 6'd0, 6'd2, 8'd1, 1'b0));
        push("a2_gameover", mk(K_ROUND, 4'h0, 4'b0010, 6'd0, 6'd2, 6'd0, 6'd2, 8'd2, 1'b1));
        judge(1'b1, 1'b0, 1'b0); drain("a2_answer");
        arm_p(4'b0000); cyc(15);
        chk("a_over_hold", now_snap(), mk(K_NONE, 4'h0, 4'b0010, 6'd0, 6'd2, 6'd0, 6'd2, 8'd2, 1'b1));
        do_reset("a_reset_clear");

        // B: tie P0/P3 twice; round-robin gives P0 then P3.
        push("b1_start", mk(K_START, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        arm_p(4'b0000); drain("b1_start");
        push("b1_grant", mk(K_GRANT, 4'b0001, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        press(4'b1001); drain("b1_grant");
        push("b1_answer", mk(K_ANS, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd2, 8'd0, 1'b0));
        push("b1_round", mk(K_ROUND, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd2, 8'd1, 1'b0));
        judge(1'b1, 1'b0, 1'b0); drain("b1_answer");
        push("b2_start", mk(K_START, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd2, 8'd1, 1'b0));
        arm_p(4'b0000); drain("b2_start");
        push("b2_grant", mk(K_GRANT, 4'b1000, 4'h0, 6'd0, 6'd0, 6'd0, 6'd2, 8'd1, 1'b0));
        press(4'b1001); drain("b2_grant");
        push("b2_answer", mk(K_ANS, 4'h0, 4'h0, 6'd2, 6'd0, 6'd0, 6'd2, 8'd1, 1'b0));
        push("b2_gameover", mk(K_ROUND, 4'h0, 4'h0, 6'd2, 6'd0, 6'd0, 6'd2, 8'd2, 1'b1));
        judge(1'b1, 1'b0, 1'b0); drain("b2_answer");
        do_reset("b_reset_clear");

        // C: P0 times out, window reopens, P1 wins; Judge_Ok beats Timer_Expired.
        push("c1_start", mk(K_START, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        arm_p(4'b0000); drain("c1_start");
        push("c1_grant_p0", mk(K_GRANT, 4'b0001, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        press(4'b0001); drain("c1_grant_p0");
        push("c1_timeout", mk(K_ANS, 4'h0, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        push("c1_reopen", mk(K_START, 4'h0, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        judge(1'b0, 1'b0, 1'b1); drain("c1_timeout");
        push("c1_grant_p1", mk(K_GRANT, 4'b0010, 4'b0001, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        press(4'b0011); drain("c1_grant_p1");
        push("c1_ok_wins", mk(K_ANS, 4'h0, 4'b0001, 6'd0, 6'd0, 6'd2, 6'd0, 8'd0, 1'b0));
        push("c1_round", mk(K_ROUND, 4'h0, 4'b0001, 6'd0, 6'd0, 6'd2, 6'd0, 8'd1, 1'b0));
        judge(1'b1, 1'b0, 1'b1); drain("c1_ok_wins");

        // C2: all four false-start; round ends without opening the window.
        push("c2_all_locked", mk(K_ROUND, 4'h0, 4'b1111, 6'd0, 6'd0, 6'd1, 6'd0, 8'd2, 1'b1));
        arm_p(4'b1111); drain("c2_all_locked");
        do_reset("c_reset_clear");

        // E: three false starts, P3 answers wrong, nobody left -> round done.
        push("e1_start", mk(K_START, 4'h0, 4'b0111, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        arm_p(4'b0111); drain("e1_start");
        push("e1_grant", mk(K_GRANT, 4'b1000, 4'b0111, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        press(4'b1000); drain("e1_grant");
        push("e1_bad", mk(K_ANS, 4'h0, 4'b1111, 6'd0, 6'd0, 6'd0, 6'd0, 8'd0, 1'b0));
        push("e1_round", mk(K_ROUND, 4'h0, 4'b1111, 6'd0, 6'd0, 6'd0, 6'd0, 8'd1, 1'b0));
        judge(1'b0, 1'b1, 1'b0); drain("e1_bad");
        cyc(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
